collision_scheduler: RTL
========================

# collision_scheduler

Time-multiplexed sequencer for the pairwise collision check. It replaces the SPRITES·(SPRITES−1)/2 parallel `detector` instances with one shared `detector`. The scheduler snapshots the sprite state on `start` and issues one sprite pair per cycle to the shared detector. From the returned hit bits it builds the symmetric collision matrix that `collision_handler` consumes. It sits between the sprite state registers and `collision_handler`, under top-level frame control.

## Interface
- SPRITES, 9, number of sprites (≥2)
- WIDTH, 32, coordinate width; 16.16 fixed point
- PAIRS (localparam), SPRITES*(SPRITES-1)/2, pairs per scan (36 at default)
- CW (localparam), $clog2(PAIRS+1), width of hit_count

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clears all state
- start  in  1  begin scan; sampled only in IDLE
- locations  in  [SPRITES-1:0][1:0][WIDTH-1:0]  sprite positions, [1]=x, [0]=y
- radii  in  [SPRITES-1:0][6:0]  sprite radii (integer units)
- masses  in  [SPRITES-1:0][WIDTH/2-1:0]  sprite masses; 0 = inactive
- det_loc_a, det_loc_b  out  [1:0][WIDTH-1:0]  registered operands to the shared detector
- det_radius_a, det_radius_b  out  [6:0]  registered radii
- det_mass_a, det_mass_b  out  [WIDTH/2-1:0]  registered masses
- det_valid  out  1  operands on det_* are a live pair
- det_collision  in  1  combinational detector result for the current det_* operands
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse; collision_matrix and hit_count are final
- collision_matrix  out  [SPRITES-1:0][SPRITES-1:0]  symmetric; diagonal is always 0
- hit_count  out  CW  number of colliding pairs (i<j) found in the last scan

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- **IDLE, start=1:**
  - Snapshot locations, radii and masses into internal arrays.
  - Clear collision_matrix and hit_count.
  - Set i=0, j=1, then go to SCAN.
  - start=0: stay in IDLE.
- **SCAN, each cycle:**
  - Register snapshot[i] to the det_*_a ports and snapshot[j] to the det_*_b ports.
  - Register pending pair index (pi,pj)=(i,j) and set det_valid=1.
  - Advance the pair: if j==SPRITES-1 then i←i+1, j←i+2; else j←j+1.
  - Pair order is (0,1),(0,2)…(0,S-1),(1,2)…(S-2,S-1). After issuing (S-2,S-1), go to DRAIN.
- **Result capture:** in any cycle where det_valid=1, sample det_collision.
  - Write collision_matrix[pi][pj] and collision_matrix[pj][pi].
  - If det_collision=1, increment hit_count.
- **DRAIN:** det_valid←0, capture the last result, go to DONE.
- **DONE:** done=1 for one cycle, go to IDLE.
- **Busy window:** busy=1 in SCAN, DRAIN and DONE.
- **Outputs hold:** collision_matrix and hit_count hold until the next accepted start.
- **Ignored start:** start in SCAN, DRAIN or DONE is ignored; nothing is queued.
- **Snapshot isolation:** input changes after the snapshot do not affect the scan in progress.
- **Operand registers:** hold their last values while det_valid=0.
- **Counter width:** hit_count cannot overflow, since CW covers PAIRS.

## Timing
- **Reset values:** every output is 0: det_* operands, det_valid, busy, done, collision_matrix, hit_count. State=IDLE.
- **Edge numbering:** start is sampled high at edge E0.
  - det_valid is high after E1 through E(PAIRS).
  - Results are written at E2 through E(PAIRS+1).
  - done is high for exactly one cycle after E(PAIRS+2).
- **Latency:** PAIRS+2 cycles from start to done; 38 at default. The scan cannot stall; throughput is one pair per cycle.
- **Detector path:** det_collision must be valid in the same cycle as the det_* operands, because the shared detector is combinational.
- **Reset mid-scan:** rst=1 at any edge gives reset values at the next cycle. The scan is abandoned and the partial matrix is discarded.
- **start with rst:** rst wins.
- **Back-to-back scans:** start sampled in the cycle after done is accepted.

## Configuration
- **SCHED_SKIP_MASSLESS_EN defined:**
  - In SCAN, a pair with snapshot mass[i]==0 or mass[j]==0 still consumes its cycle.
  - det_valid=0 for that cycle and the det_* operand registers hold.
  - The matrix entry is written 0 directly; hit_count is unchanged.
  - Latency is unchanged, so scan timing stays deterministic.
- **Not defined:** every pair is issued with det_valid=1. Massless gating is left to the detector.

## Test plan
- **No collisions:** reset, SPRITES=9, sprite k at x=k·100.0, y=0, radius 5, mass 1; pulse start. Required: done exactly 38 cycles later, matrix all 0, hit_count=0, 36 det_valid cycles.
- **Pair order:** monitor det_loc_a/det_loc_b during the scan. Required sequence is (0,1),(0,2)…(7,8), with no repeats and no diagonal pairs.
- **Radius threshold:** sprite 0 at (0,0), sprite 1 at (10.0,0).
  - Radii 6 and 5: matrix[0][1]=matrix[1][0]=1, hit_count=1.
  - Radii 4 and 5: both entries 0, hit_count=0.
- **start and input changes during a scan:** hold start high through a scan and move sprite 1 away at cycle 5. Required: the result reflects the snapshot, there is no retrigger before done, and the next scan (start still high) begins the cycle after done.
- **Reset mid-scan:** assert rst at cycle 10 of the scan. Required: next cycle busy=0, det_valid=0, matrix 0, hit_count 0. A following start completes normally in 38 cycles.
- **SCHED_SKIP_MASSLESS_EN:** sprite 4 mass 0, overlapping sprite 5.
  - With the macro: det_valid=0 on all 8 pairs involving sprite 4, entries 0, latency still 38.
  - Without the macro: those pairs are issued with det_valid=1.

Source files
------------

// File: rtl/collision_scheduler.sv
// Shares one combinational pair detector across all sprite pairs, one snapshot pair per cycle.
// Latency: PAIRS+2 cycles from accepted start to the done pulse; never stalls.
// Backpressure: none; start is ignored while busy. SCHED_SKIP_MASSLESS_EN idles the detector on massless pairs.
module collision_scheduler #(
  parameter int SPRITES = 9,
  parameter int WIDTH   = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [SPRITES-1:0][1:0][WIDTH-1:0]     locations,
  input  logic [SPRITES-1:0][6:0]                radii,
  input  logic [SPRITES-1:0][WIDTH/2-1:0]        masses,
  output logic [1:0][WIDTH-1:0]                  det_loc_a,
  output logic [1:0][WIDTH-1:0]                  det_loc_b,
  output logic [6:0]                             det_radius_a,
  output logic [6:0]                             det_radius_b,
  output logic [WIDTH/2-1:0]                     det_mass_a,
  output logic [WIDTH/2-1:0]                     det_mass_b,
  output logic                                   det_valid,
  input  logic                                   det_collision,
  output logic                                   busy,
  output logic                                   done,
  output logic [SPRITES-1:0][SPRITES-1:0]        collision_matrix,
  output logic [$clog2(SPRITES*(SPRITES-1)/2+1)-1:0] hit_count
);
  localparam int PAIRS = SPRITES * (SPRITES - 1) / 2;
  localparam int CW    = $clog2(PAIRS + 1);
  localparam int IW    = $clog2(SPRITES);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t state, state_n;

  logic [SPRITES-1:0][1:0][WIDTH-1:0] snap_loc;
  logic [SPRITES-1:0][6:0]            snap_rad;
  logic [SPRITES-1:0][WIDTH/2-1:0]    snap_mass;

  logic [IW-1:0] cur_i, cur_j;
  logic [IW-1:0] pend_i, pend_j;
  logic          last_pair;
  logic          skip;

  assign last_pair = (cur_i == IW'(SPRITES - 2)) && (cur_j == IW'(SPRITES - 1));

  always_comb begin
`ifdef SCHED_SKIP_MASSLESS_EN
    skip = (snap_mass[cur_i] == '0) || (snap_mass[cur_j] == '0);
`else
    skip = 1'b0;
`endif
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    case (state)
      IDLE:  if (start) state_n = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (last_pair) state_n = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      snap_loc         <= '0;
      snap_rad         <= '0;
      snap_mass        <= '0;
      cur_i            <= '0;
      cur_j            <= '0;
      pend_i           <= '0;
      pend_j           <= '0;
      det_loc_a        <= '0;
      det_loc_b        <= '0;
      det_radius_a     <= '0;
      det_radius_b     <= '0;
      det_mass_a       <= '0;
      det_mass_b       <= '0;
      det_valid        <= 1'b0;
      done             <= 1'b0;
      collision_matrix <= '0;
      hit_count        <= '0;
    end else begin
      state <= state_n;
      done  <= (state == DONE);

      // Result for the pair presented last cycle; the detector answers combinationally.
      if (det_valid) begin
        collision_matrix[pend_i][pend_j] <= det_collision;
        collision_matrix[pend_j][pend_i] <= det_collision;
        hit_count                        <= hit_count + CW'(det_collision);
      end

      case (state)
        IDLE: begin
          if (start) begin
            snap_loc         <= locations;
            snap_rad         <= radii;
            snap_mass        <= masses;
            collision_matrix <= '0;
            hit_count        <= '0;
            cur_i            <= '0;
            cur_j            <= IW'(1);
          end
        end
        SCAN: begin
          pend_i <= cur_i;
          pend_j <= cur_j;
          if (skip) begin
            // Massless pair keeps its slot so scan timing stays fixed; operands hold.
            det_valid                      <= 1'b0;
            collision_matrix[cur_i][cur_j] <= 1'b0;
            collision_matrix[cur_j][cur_i] <= 1'b0;
          end else begin
            det_valid    <= 1'b1;
            det_loc_a    <= snap_loc[cur_i];
            det_loc_b    <= snap_loc[cur_j];
            det_radius_a <= snap_rad[cur_i];
            det_radius_b <= snap_rad[cur_j];
            det_mass_a   <= snap_mass[cur_i];
            det_mass_b   <= snap_mass[cur_j];
          end
          if (cur_j == IW'(SPRITES - 1)) begin
            cur_i <= cur_i + IW'(1);
            cur_j <= cur_i + IW'(2);
          end else begin
            cur_j <= cur_j + IW'(1);
          end
        end
        DRAIN:   det_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
